// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline stage registers.
package pipe_pkg;

    // Default payload width of the MIPS datapath.
    localparam int DATA_W = 32;

    // sll $0,$0,0 encodes as all zeros.
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    // Stage occupancy states; the encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_en_reg.sv
// Enable-loaded register with asynchronous active-low reset to a fixed value.
module pipe_en_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    // Load d when enabled; otherwise hold the current value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg <= RESET_VAL;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with a 2-entry skid buffer and flush.
// Entry 0 (main) is the head presented downstream; entry 1 (skid) is the
// younger entry captured when downstream stalls while upstream pushes.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = DATA_W,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam int MAIN = 0;
    localparam int SKID = 1;

    state_t state_reg;
    state_t state_next;

    logic             entry_en   [2];
    logic [WIDTH-1:0] entry_next [2];
    logic [WIDTH-1:0] entry_q    [2];

    logic accept;
    logic issue;

    // in_ready and out_valid come straight from the state register, so there
    // is no combinational path from out_ready to in_ready.
    assign in_ready  = (state_reg != ST_FULL);
    assign out_valid = (state_reg != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;

    // Main is reloaded with BUBBLE whenever the stage empties, so it can be
    // presented directly without a mux on out_valid.
    assign out_data  = entry_q[MAIN];
    assign occupancy = state_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            pipe_en_reg #(
                .WIDTH     (WIDTH),
                .RESET_VAL (BUBBLE)
            ) u_entry (
                .clk   (clk),
                .reset (reset),
                .en    (entry_en[gi]),
                .d     (entry_next[gi]),
                .q     (entry_q[gi])
            );
        end
    endgenerate

    // State register; reset drops any held entry immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and entry load control; flush overrides all transfers.
    always_comb begin
        state_next       = state_reg;
        entry_en[MAIN]   = 1'b0;
        entry_en[SKID]   = 1'b0;
        entry_next[MAIN] = entry_q[MAIN];
        entry_next[SKID] = entry_q[SKID];

        if (flush) begin
            // An accept this cycle completes upstream but its data is dropped;
            // an issue this cycle already happened downstream.
            state_next       = ST_EMPTY;
            entry_en[MAIN]   = 1'b1;
            entry_en[SKID]   = 1'b1;
            entry_next[MAIN] = BUBBLE;
            entry_next[SKID] = BUBBLE;
        end else begin
            unique case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        entry_en[MAIN]   = 1'b1;
                        entry_next[MAIN] = in_data;
                        state_next       = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (accept && issue) begin
                        entry_en[MAIN]   = 1'b1;
                        entry_next[MAIN] = in_data;
                    end else if (accept) begin
                        entry_en[SKID]   = 1'b1;
                        entry_next[SKID] = in_data;
                        state_next       = ST_FULL;
                    end else if (issue) begin
                        entry_en[MAIN]   = 1'b1;
                        entry_next[MAIN] = BUBBLE;
                        state_next       = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (issue) begin
                        entry_en[MAIN]   = 1'b1;
                        entry_next[MAIN] = entry_q[SKID];
                        entry_en[SKID]   = 1'b1;
                        entry_next[SKID] = BUBBLE;
                        state_next       = ST_HALF;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // The state encoding never reaches 3.
    a_occ_legal: assert property (@(posedge clk) disable iff (!reset) occupancy != 2'd3);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (32-bit default and 8-bit variant).
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in_data8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  out_data8;
    logic [1:0]  occupancy8;

    int checks;
    int errors;

    pipe_stage_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_stage_reg #(
        .WIDTH  (8),
        .BUBBLE (8'hFF)
    ) dut8 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .occupancy (occupancy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 32'h0;
        out_ready  = 1'b0;
        in_valid8  = 1'b0;
        in_data8   = 8'h0;
        out_ready8 = 1'b0;

        // Reset values.
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_occupancy", {30'b0, occupancy}, 32'h0);
        check("rst_out_data8", {24'b0, out_data8}, 32'hFF);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Fill to FULL, then assert reset asynchronously mid-cycle.
        in_valid = 1'b1;
        in_data  = 32'h11;
        tick();
        check("fill_occ1", {30'b0, occupancy}, 32'h1);
        check("fill_head", out_data, 32'h11);
        in_data = 32'h22;
        tick();
        in_valid = 1'b0;
        check("fill_occ2", {30'b0, occupancy}, 32'h2);
        check("fill_in_ready", {31'b0, in_ready}, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'h0);
        check("arst_out_data", out_data, 32'h0);
        check("arst_in_ready", {31'b0, in_ready}, 32'h1);
        check("arst_occupancy", {30'b0, occupancy}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Streaming at one entry per cycle.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            tick();
            check($sformatf("stream_data_%0d", i), out_data, 32'(i));
            check($sformatf("stream_valid_%0d", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("stream_in_ready_%0d", i), {31'b0, in_ready}, 32'h1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", {31'b0, out_valid}, 32'h0);
        check("stream_drain_data", out_data, 32'h0);

        // Backpressure: two pushes while stalled, then release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        check("bp_occ", {30'b0, occupancy}, 32'h2);
        check("bp_in_ready", {31'b0, in_ready}, 32'h0);
        check("bp_head", out_data, 32'hA);
        tick();
        check("bp_hold_head", out_data, 32'hA);
        check("bp_hold_occ", {30'b0, occupancy}, 32'h2);
        out_ready = 1'b1;
        tick();
        check("bp_second", out_data, 32'hB);
        check("bp_in_ready_back", {31'b0, in_ready}, 32'h1);
        check("bp_occ_half", {30'b0, occupancy}, 32'h1);
        tick();
        check("bp_empty_valid", {31'b0, out_valid}, 32'h0);

        // Flush from FULL with an offered entry that must never appear.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hC;
        tick();
        in_data = 32'hD;
        tick();
        check("fl_full_occ", {30'b0, occupancy}, 32'h2);
        flush   = 1'b1;
        in_data = 32'hE;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_occ", {30'b0, occupancy}, 32'h0);
        check("fl_out_valid", {31'b0, out_valid}, 32'h0);
        check("fl_out_data", out_data, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("fl_no_e_%0d", i), {31'b0, out_valid}, 32'h0);
        end

        // Flush with concurrent issue and a discarded accept from HALF.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5;
        tick();
        in_data   = 32'h77;
        out_ready = 1'b1;
        flush     = 1'b1;
        check("fli_issue_valid", {31'b0, out_valid}, 32'h1);
        check("fli_issue_data", out_data, 32'h5);
        check("fli_accept_ready", {31'b0, in_ready}, 32'h1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fli_occ", {30'b0, occupancy}, 32'h0);
        check("fli_out_valid", {31'b0, out_valid}, 32'h0);
        tick();
        check("fli_no_77", {31'b0, out_valid}, 32'h0);

        // 8-bit variant with a non-zero bubble.
        check("w8_idle", {24'b0, out_data8}, 32'hFF);
        in_valid8 = 1'b1;
        in_data8  = 8'h3C;
        tick();
        in_valid8 = 1'b0;
        check("w8_data", {24'b0, out_data8}, 32'h3C);
        check("w8_valid", {31'b0, out_valid8}, 32'h1);
        out_ready8 = 1'b1;
        tick();
        check("w8_bubble_after_issue", {24'b0, out_data8}, 32'hFF);
        check("w8_occ", {30'b0, occupancy8}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register for the MIPS datapath. It replaces plain free-running 32-bit registers between stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready flow control, a 2-entry skid buffer for full throughput under backpressure, synchronous flush (bubble insertion) and a defined bubble value.
- Proper async reset replaces X-detection initialisation.

Parameters:
- WIDTH, 32: payload width in bits.
- BUBBLE, {WIDTH{1'b0}}: value driven on out_data when no valid entry is held. Default is the MIPS NOP (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; squash all held entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept; registered, equals (state != FULL).
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.
- out_data  output  WIDTH  head payload, or BUBBLE when out_valid=0.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Clock and reset: one clock is used. Reset is asynchronous and active-low, port named reset.
- Reset values: state=EMPTY, out_valid=0, out_data=BUBBLE, in_ready=1, occupancy=0, skid register=BUBBLE.
- Reset mid-transfer: any held or in-flight entry is lost. No partial update may survive.
- Handshake definitions:
  - Accept = in_valid & in_ready.
  - Issue = out_valid & out_ready.
  - in_data is sampled only on accept.
  - out_data/out_valid hold stable while out_valid=1 & out_ready=0.
- Latency: an accepted entry appears on out_valid/out_data the next cycle.
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready depends only on registered state. There is no combinational path from out_ready to in_ready.
- States: EMPTY (occ 0), HALF (main valid, occ 1), FULL (main + skid valid, occ 2).
- EMPTY:
  - accept -> main<=in_data, go HALF.
  - otherwise stay.
- HALF:
  - accept & issue -> main<=in_data, stay HALF.
  - accept only -> skid<=in_data, go FULL.
  - issue only -> main<=BUBBLE, go EMPTY.
  - neither -> hold.
- FULL (in_ready=0, no accept possible):
  - issue -> main<=skid, skid<=BUBBLE, go HALF.
  - otherwise hold.
- Ordering: strict FIFO. The skid entry is always younger than the main entry.
- flush:
  - Highest priority below reset. Next state is EMPTY; main and skid both become BUBBLE.
  - An accept in the same cycle is consumed upstream (handshake completes) and discarded.
  - An issue in the same cycle completes normally, since the downstream already saw out_valid.
- Registers are never driven X after reset. No X-dependent logic is permitted.
- Widths: occupancy is 2 bits; value 3 is unreachable. An SVA assertion flags it.

Decomposition:
- Package pipe_pkg:
  - state encoding ST_EMPTY=2'd0, ST_HALF=2'd1, ST_FULL=2'd2.
  - constant MIPS_NOP=32'h0000_0000.
  - default width constant DATA_W=32.
- One sub-module, pipe_en_reg: WIDTH/RESET_VAL parametrised, enable-loaded register with async active-low reset. It is instantiated for the main and skid entries.
- FSM and control remain in pipe_stage_reg.

Test Plan:
- Reset mid-FULL: fill with 0x11, 0x22 holding out_ready=0; assert reset low -> same instant out_valid=0, out_data=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1, push 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on consecutive cycles, each 1 cycle after accept, in_ready constantly 1.
- Backpressure: push 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready=0 next cycle, out_data=0xA held. Release out_ready -> issue 0xA then 0xB, in_ready returns to 1 after first issue.
- Flush: hold 0xC, 0xD (FULL), pulse flush with in_valid=1 in_data=0xE -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE; 0xE never appears.
- Flush with concurrent issue: HALF holding 0x5, out_ready=1, flush=1 -> 0x5 counted as issued, next cycle EMPTY.
- Parameter sweep: WIDTH=8, BUBBLE=8'hFF -> idle out_data=0xFF. Push 0x3C -> out_data=0x3C one cycle later.
